mem_arbiter: RTL and testbench

Two-requester controller for the single unified line-wide RAM port. It shares that port between the instruction cache (read-only line fills) and the load/store unit (word reads and byte-masked writes). It owns the RAM address, write-enable, write data and byte-mask, and sequences each access through a fixed-latency state machine.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, LSU and RAM-port signals around mem_arbiter.
// slave = arbiter view, master = requesters plus RAM view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int LINE_WIDTH = 128,
  parameter int WORD_WIDTH = 32
);
  logic                    ic_req;
  logic [ADDR_WIDTH-1:0]   ic_addr;
  logic                    ic_done;
  logic [LINE_WIDTH-1:0]   ic_line;

  logic                    ls_req;
  logic                    ls_we;
  logic [ADDR_WIDTH-1:0]   ls_addr;
  logic [3:0]              ls_be;
  logic [WORD_WIDTH-1:0]   ls_wdata;
  logic                    ls_flush;
  logic                    ls_done;
  logic [WORD_WIDTH-1:0]   ls_rdata;

  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [LINE_WIDTH-1:0]   ram_dout;
  logic                    ram_we;
  logic [LINE_WIDTH-1:0]   ram_wdata;
  logic [LINE_WIDTH/8-1:0] ram_wmask;

  modport slave (
    input  ic_req, ic_addr, ls_req, ls_we, ls_addr, ls_be, ls_wdata, ls_flush, ram_dout,
    output ic_done, ic_line, ls_done, ls_rdata, ram_addr, ram_we, ram_wdata, ram_wmask
  );

  modport master (
    output ic_req, ic_addr, ls_req, ls_we, ls_addr, ls_be, ls_wdata, ls_flush, ram_dout,
    input  ic_done, ic_line, ls_done, ls_rdata, ram_addr, ram_we, ram_wdata, ram_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one line-wide RAM port between icache fills and LSU word accesses.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; otherwise LSU wins ties.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int LINE_WIDTH = 128,
  parameter int WORD_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  mem_arbiter_if.slave  bus
);
  localparam int MASK_W = LINE_WIDTH / 8;
  localparam int LANES  = LINE_WIDTH / WORD_WIDTH;

  typedef enum logic [2:0] {IDLE, IC_ADDR, IC_DATA, LS_ADDR, LS_DATA, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic                    ram_we_q, ram_we_d;
  logic [LINE_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic [MASK_W-1:0]       ram_wmask_q, ram_wmask_d;
  logic [LINE_WIDTH-1:0]   ic_line_q, ic_line_d;
  logic [WORD_WIDTH-1:0]   ls_rdata_q, ls_rdata_d;
  logic                    ic_done_q, ic_done_d;
  logic                    ls_done_q, ls_done_d;
  logic [1:0]              ls_off_q, ls_off_d;
  logic                    ls_we_q, ls_we_d;
  logic                    ls_ok;
  logic                    pick_ls;
  logic                    unused_ic_low;

`ifdef MEM_ARBITER_RR_EN
  // 1 = LSU won the last grant
  logic                    ptr_q, ptr_d;
  assign pick_ls = ls_ok & (~bus.ic_req | ~ptr_q);
`else
  assign pick_ls = ls_ok;
`endif

  assign ls_ok         = bus.ls_req & ~bus.ls_flush;
  assign unused_ic_low = &{1'b0, bus.ic_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = ram_we_q;
    ram_wdata_d = ram_wdata_q;
    ram_wmask_d = ram_wmask_q;
    ic_line_d   = ic_line_q;
    ls_rdata_d  = ls_rdata_q;
    ic_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    ls_off_d    = ls_off_q;
    ls_we_d     = ls_we_q;
`ifdef MEM_ARBITER_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_ls) begin
          state_d    = LS_ADDR;
          ram_addr_d = {bus.ls_addr[ADDR_WIDTH-1:2], 2'b00};
          ls_off_d   = bus.ls_addr[1:0];
          ls_we_d    = bus.ls_we;
          ram_we_d   = bus.ls_we;
          if (bus.ls_we) begin
            ram_wdata_d = {LANES{bus.ls_wdata}};
            ram_wmask_d = MASK_W'(bus.ls_be) << {bus.ls_addr[1:0], 2'b00};
          end
`ifdef MEM_ARBITER_RR_EN
          ptr_d = 1'b1;
`endif
        end else if (bus.ic_req) begin
          state_d    = IC_ADDR;
          ram_addr_d = {bus.ic_addr[ADDR_WIDTH-1:2], 2'b00};
`ifdef MEM_ARBITER_RR_EN
          ptr_d = 1'b0;
`endif
        end
      end
      IC_ADDR: state_d = IC_DATA;
      IC_DATA: begin
        ic_line_d = bus.ram_dout;
        ic_done_d = 1'b1;
        state_d   = DONE;
      end
      LS_ADDR: begin
        // a write commits on this edge, so a flush can no longer cancel it
        if (ls_we_q) begin
          ram_we_d  = 1'b0;
          ls_done_d = 1'b1;
          state_d   = DONE;
        end else if (bus.ls_flush) begin
          state_d = IDLE;
        end else begin
          state_d = LS_DATA;
        end
      end
      LS_DATA: begin
        if (bus.ls_flush) begin
          state_d = IDLE;
        end else begin
          ls_rdata_d = bus.ram_dout[32'(ls_off_q)*WORD_WIDTH +: WORD_WIDTH];
          ls_done_d  = 1'b1;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      ram_wmask_q <= '0;
      ic_line_q   <= '0;
      ls_rdata_q  <= '0;
      ic_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      ls_off_q    <= 2'b00;
      ls_we_q     <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      ptr_q       <= 1'b1;
`endif
    end else if (rdy) begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wmask_q <= ram_wmask_d;
      ic_line_q   <= ic_line_d;
      ls_rdata_q  <= ls_rdata_d;
      ic_done_q   <= ic_done_d;
      ls_done_q   <= ls_done_d;
      ls_off_q    <= ls_off_d;
      ls_we_q     <= ls_we_d;
`ifdef MEM_ARBITER_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // the registered write enable survives a stall; the RAM must not see it
  assign bus.ram_we    = ram_we_q & rdy;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_wmask = ram_wmask_q;
  assign bus.ic_line   = ic_line_q;
  assign bus.ic_done   = ic_done_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.ls_done   = ls_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small line RAM model.
// RAM word at word address k initially holds 32'hA500_0000 | k.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  logic rdy;
  int   vectors;
  int   errs;
  logic exp_ls [3];

  mem_arbiter_if #(.ADDR_WIDTH(17), .LINE_WIDTH(128), .WORD_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(17), .LINE_WIDTH(128), .WORD_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] mem [256];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++)
        for (int j = 0; j < 4; j++)
          mem[i][j*32 +: 32] <= 32'hA500_0000 | 32'(i*4 + j);
    end else if (bus.ram_we) begin
      for (int b = 0; b < 16; b++)
        if (bus.ram_wmask[b]) mem[bus.ram_addr[9:2]][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
    end
    bus.ram_dout <= mem[bus.ram_addr[9:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    vectors = 0;
    errs    = 0;
`ifdef MEM_ARBITER_RR_EN
    exp_ls = '{1'b0, 1'b1, 1'b0};
`else
    exp_ls = '{1'b1, 1'b1, 1'b1};
`endif
    rst = 1'b1;
    rdy = 1'b1;
    bus.ic_req = 1'b0; bus.ic_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0;
    bus.ls_be = 4'h0;  bus.ls_wdata = '0; bus.ls_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ic_done", bus.ic_done, 1'b0);
    chk("rst_ls_done", bus.ls_done, 1'b0);
    chk("rst_ram_we", bus.ram_we, 1'b0);
    chk("rst_ram_addr", bus.ram_addr, 17'h0);
    chk("rst_wmask", bus.ram_wmask, 16'h0);
    rst = 1'b0;

    // icache fill of 0x00105
    bus.ic_req = 1'b1; bus.ic_addr = 17'h00105;
    tick();
    chk("ic_addr_e0", bus.ram_addr, 17'h00104);
    chk("ic_done_e0", bus.ic_done, 1'b0);
    tick();
    chk("ic_done_e1", bus.ic_done, 1'b0);
    tick();
    chk("ic_done_e2", bus.ic_done, 1'b1);
    chk("ic_line", bus.ic_line, {32'hA500_0107, 32'hA500_0106, 32'hA500_0105, 32'hA500_0104});
    bus.ic_req = 1'b0;
    tick();
    chk("ic_done_width", bus.ic_done, 1'b0);

    // LSU write to 0x00022
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 17'h00022;
    bus.ls_be = 4'b0011; bus.ls_wdata = 32'hDEAD_BEEF;
    tick();
    chk("wr_ram_we", bus.ram_we, 1'b1);
    chk("wr_wmask", bus.ram_wmask, 16'h0300);
    chk("wr_wdata", bus.ram_wdata, {4{32'hDEAD_BEEF}});
    chk("wr_ram_addr", bus.ram_addr, 17'h00020);
    chk("wr_done_e0", bus.ls_done, 1'b0);
    tick();
    chk("wr_done_e1", bus.ls_done, 1'b1);
    chk("wr_we_off", bus.ram_we, 1'b0);
    bus.ls_req = 1'b0;
    tick();
    chk("wr_done_width", bus.ls_done, 1'b0);

    // read back merged word; ls_addr changes after grant
    bus.ls_req = 1'b1; bus.ls_we = 1'b0;
    tick();
    bus.ls_addr = 17'h00021;
    tick();
    chk("rd_done_e1", bus.ls_done, 1'b0);
    tick();
    chk("rd_done_e2", bus.ls_done, 1'b1);
    chk("rd_merged", bus.ls_rdata, 32'hA500_BEEF);
    bus.ls_req = 1'b0;
    tick();

    // simultaneous held requests
    bus.ic_req = 1'b1; bus.ic_addr = 17'h00105;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 17'h00023;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!(bus.ic_done || bus.ls_done) && n < 10) begin
        tick();
        n++;
      end
      chk("tie_wait", n < 10, 1'b1);
      chk("tie_ls_done", bus.ls_done, exp_ls[k]);
      chk("tie_ic_done", bus.ic_done, !exp_ls[k]);
      if (exp_ls[k]) chk("tie_rdata", bus.ls_rdata, 32'hA500_0023);
      else           chk("tie_line", bus.ic_line, {32'hA500_0107, 32'hA500_0106, 32'hA500_0105, 32'hA500_0104});
      tick();
    end
    bus.ic_req = 1'b0; bus.ls_req = 1'b0;
    tick();

    // flush in LS_DATA cancels the read
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 17'h00031;
    tick();
    tick();
    bus.ls_flush = 1'b1;
    tick();
    chk("flush_no_done", bus.ls_done, 1'b0);
    bus.ls_flush = 1'b0; bus.ls_req = 1'b0;

    // immediate grant proves IDLE; then stall in IC_DATA
    bus.ic_req = 1'b1; bus.ic_addr = 17'h000F2;
    tick();
    chk("post_flush_grant", bus.ram_addr, 17'h000F0);
    tick();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_ic_done", bus.ic_done, 1'b0);
      chk("stall_ram_we", bus.ram_we, 1'b0);
    end
    rdy = 1'b1;
    tick();
    chk("stall_ic_done_after", bus.ic_done, 1'b1);
    chk("stall_ic_line", bus.ic_line, {32'hA500_00F3, 32'hA500_00F2, 32'hA500_00F1, 32'hA500_00F0});
    bus.ic_req = 1'b0;
    tick();

    // write with rdy gating and a flush that must be ignored
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 17'h00041;
    bus.ls_be = 4'hF; bus.ls_wdata = 32'h1234_5678;
    tick();
    chk("wr2_ram_we", bus.ram_we, 1'b1);
    chk("wr2_wmask", bus.ram_wmask, 16'h00F0);
    rdy = 1'b0;
    #1;
    chk("rdy_gates_we", bus.ram_we, 1'b0);
    tick();
    chk("frozen_ls_done", bus.ls_done, 1'b0);
    rdy = 1'b1;
    #1;
    chk("rdy_restores_we", bus.ram_we, 1'b1);
    bus.ls_flush = 1'b1;
    tick();
    chk("wr_flush_done", bus.ls_done, 1'b1);
    bus.ls_flush = 1'b0; bus.ls_req = 1'b0;
    tick();
    bus.ls_req = 1'b1; bus.ls_we = 1'b0;
    tick();
    tick();
    tick();
    chk("wr_flush_data", bus.ls_rdata, 32'h1234_5678);
    bus.ls_req = 1'b0;
    tick();

    // asynchronous reset in the middle of a write
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 17'h00050;
    bus.ls_be = 4'hF; bus.ls_wdata = 32'hCAFE_F00D;
    tick();
    chk("rst_wr_we_pre", bus.ram_we, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ram_we", bus.ram_we, 1'b0);
    chk("arst_ram_addr", bus.ram_addr, 17'h0);
    chk("arst_wdata", bus.ram_wdata, 128'h0);
    chk("arst_wmask", bus.ram_wmask, 16'h0);
    chk("arst_ic_line", bus.ic_line, 128'h0);
    chk("arst_ls_rdata", bus.ls_rdata, 32'h0);
    #1 rst = 1'b0;
    bus.ls_req = 1'b0;
    tick();
    chk("arst_no_done0", bus.ls_done, 1'b0);
    tick();
    chk("arst_no_done1", bus.ls_done, 1'b0);
    bus.ls_req = 1'b1; bus.ls_we = 1'b0;
    tick();
    tick();
    tick();
    chk("arst_not_written", bus.ls_rdata, 32'hA500_0050);
    bus.ls_req = 1'b0;
    tick();

    // flush in IDLE masks ls_req
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 17'h00063; bus.ls_flush = 1'b1;
    tick();
    chk("idle_flush_mask", bus.ram_addr, 17'h00050);
    bus.ls_flush = 1'b0;
    tick();
    chk("idle_flush_grant", bus.ram_addr, 17'h00060);
    tick();
    tick();
    chk("idle_flush_done", bus.ls_done, 1'b1);
    chk("idle_flush_rdata", bus.ls_rdata, 32'hA500_0063);
    bus.ls_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
